// File: rtl/eu_operand_collector.sv
// -----------------------------------------------------------------------------
// eu_operand_collector
//
// Sits between the execution-unit instruction queue and the ALU. It pops one
// instruction at a time, collects up to two source operands through a single
// shared register-file read port, and offers the completed instruction to the
// ALU with a valid/ready handshake.
//
// Optional feature, selected at build time:
//   EU_OPCOLLECT_BYPASS_EN - when defined, operands may also be captured from
//                            the result broadcast bus (res_*). When undefined,
//                            the res_* ports exist but are ignored.
// -----------------------------------------------------------------------------
module eu_operand_collector #(
    parameter int INSTR_WIDTH = 32,
    parameter int TAG_WIDTH   = 6,
    parameter int DATA_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   reset,

    // Instruction queue head
    input  logic [INSTR_WIDTH-1:0] instr_i,
    input  logic [TAG_WIDTH-1:0]   instr_opa_tag_i,
    input  logic [TAG_WIDTH-1:0]   instr_opb_tag_i,
    input  logic                   instr_opa_needed_i,
    input  logic                   instr_opb_needed_i,
    input  logic                   instr_valid_i,
    output logic                   instr_ready_o,

    // Shared register-file read port
    output logic                   rf_req_valid_o,
    output logic [TAG_WIDTH-1:0]   rf_req_tag_o,
    input  logic                   rf_req_ready_i,
    input  logic                   rf_resp_valid_i,
    input  logic [DATA_WIDTH-1:0]  rf_resp_data_i,

    // Result broadcast bus
    input  logic                   res_valid_i,
    input  logic [TAG_WIDTH-1:0]   res_tag_i,
    input  logic [DATA_WIDTH-1:0]  res_data_i,

    // ALU issue port
    output logic                   issue_valid_o,
    output logic [INSTR_WIDTH-1:0] issue_instr_o,
    output logic [DATA_WIDTH-1:0]  issue_opa_o,
    output logic [DATA_WIDTH-1:0]  issue_opb_o,
    input  logic                   issue_ready_i
);

    // -------------------------------------------------------------------------
    // State encoding
    // -------------------------------------------------------------------------
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_ISSUE   = 2'd2;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    logic [1:0]             r_state;

    logic [INSTR_WIDTH-1:0] r_instr;
    logic [TAG_WIDTH-1:0]   r_tag_a;
    logic [TAG_WIDTH-1:0]   r_tag_b;
    logic                   r_need_a;
    logic                   r_need_b;
    logic                   r_have_a;
    logic                   r_have_b;
    logic [DATA_WIDTH-1:0]  r_data_a;
    logic [DATA_WIDTH-1:0]  r_data_b;

    // One RF read may be in flight. r_out_is_b records which operand it was
    // issued for; r_out_stale marks a read that belongs to an instruction that
    // has already left (its response must only clear the in-flight flag).
    logic                   r_outstanding;
    logic                   r_out_is_b;
    logic                   r_out_stale;

    // -------------------------------------------------------------------------
    // Wires
    // -------------------------------------------------------------------------
    logic                   w_in_idle;
    logic                   w_in_collect;
    logic                   w_in_issue;
    logic                   w_issue_hs;
    logic                   w_accept;

    logic                   w_byp_acc_a;
    logic                   w_byp_acc_b;
    logic                   w_byp_col_a;
    logic                   w_byp_col_b;
    logic [DATA_WIDTH-1:0]  w_byp_data;

    logic                   w_acc_have_a;
    logic                   w_acc_have_b;
    logic                   w_acc_both;
    logic [DATA_WIDTH-1:0]  w_acc_data_a;
    logic [DATA_WIDTH-1:0]  w_acc_data_b;

    logic                   w_want_a;
    logic                   w_want_b;
    logic                   w_req_hs;
    logic                   w_req_is_b;

    logic                   w_resp;
    logic                   w_resp_live;
    logic                   w_wr_a;
    logic                   w_wr_b;
    logic                   w_have_a_nxt;
    logic                   w_have_b_nxt;

    // -------------------------------------------------------------------------
    // State decode and handshakes
    // -------------------------------------------------------------------------
    assign w_in_idle    = (r_state == S_IDLE);
    assign w_in_collect = (r_state == S_COLLECT);
    assign w_in_issue   = (r_state == S_ISSUE);

    assign w_issue_hs   = w_in_issue && issue_ready_i;

    // The pop request is gated by reset directly so the queue sees it drop the
    // moment reset asserts. In ISSUE it follows the ALU handshake so that a
    // waiting queue head is taken in the same cycle the current one leaves.
    assign instr_ready_o = !reset && (w_in_idle || w_issue_hs);
    assign w_accept      = instr_valid_i && instr_ready_o;

    // -------------------------------------------------------------------------
    // Result-bus capture
    // -------------------------------------------------------------------------
`ifdef EU_OPCOLLECT_BYPASS_EN
    // Acceptance-cycle match against the incoming tags (only used with w_accept).
    assign w_byp_acc_a = res_valid_i && instr_opa_needed_i && (res_tag_i == instr_opa_tag_i);
    assign w_byp_acc_b = res_valid_i && instr_opb_needed_i && (res_tag_i == instr_opb_tag_i);
    // COLLECT-state match against a latched, still-missing operand.
    assign w_byp_col_a = w_in_collect && r_need_a && !r_have_a && res_valid_i &&
                         (res_tag_i == r_tag_a);
    assign w_byp_col_b = w_in_collect && r_need_b && !r_have_b && res_valid_i &&
                         (res_tag_i == r_tag_b);
    assign w_byp_data  = res_data_i;
`else
    assign w_byp_acc_a = 1'b0;
    assign w_byp_acc_b = 1'b0;
    assign w_byp_col_a = 1'b0;
    assign w_byp_col_b = 1'b0;
    assign w_byp_data  = '0;

    // Broadcast bus is intentionally unused in this build.
    logic w_unused_res;
    assign w_unused_res = ^{res_valid_i, res_tag_i, res_data_i};
`endif

    // -------------------------------------------------------------------------
    // Acceptance values: a not-needed operand counts as present with data 0.
    // -------------------------------------------------------------------------
    assign w_acc_have_a = !instr_opa_needed_i || w_byp_acc_a;
    assign w_acc_have_b = !instr_opb_needed_i || w_byp_acc_b;
    assign w_acc_both   = w_acc_have_a && w_acc_have_b;
    assign w_acc_data_a = w_byp_acc_a ? w_byp_data : '0;
    assign w_acc_data_b = w_byp_acc_b ? w_byp_data : '0;

    // -------------------------------------------------------------------------
    // RF request: A before B, one at a time. A same-cycle bus capture removes
    // the operand from the request before the RF can accept it.
    // -------------------------------------------------------------------------
    assign w_want_a       = !r_have_a && !w_byp_col_a;
    assign w_want_b       = !r_have_b && !w_byp_col_b;
    assign rf_req_valid_o = w_in_collect && !r_outstanding && (w_want_a || w_want_b);
    assign rf_req_tag_o   = w_want_a ? r_tag_a : r_tag_b;
    assign w_req_hs       = rf_req_valid_o && rf_req_ready_i;
    assign w_req_is_b     = !w_want_a;

    // -------------------------------------------------------------------------
    // RF response: always clears the in-flight flag; only writes an operand of
    // the current instruction that is still missing.
    // -------------------------------------------------------------------------
    assign w_resp       = r_outstanding && rf_resp_valid_i;
    assign w_resp_live  = w_resp && !r_out_stale && w_in_collect;
    assign w_wr_a       = w_resp_live && !r_out_is_b && !r_have_a && !w_byp_col_a;
    assign w_wr_b       = w_resp_live &&  r_out_is_b && !r_have_b && !w_byp_col_b;
    assign w_have_a_nxt = r_have_a || w_byp_col_a || w_wr_a;
    assign w_have_b_nxt = r_have_b || w_byp_col_b || w_wr_b;

    // -------------------------------------------------------------------------
    // Outputs to the ALU come straight from the held registers.
    // -------------------------------------------------------------------------
    assign issue_valid_o = w_in_issue;
    assign issue_instr_o = r_instr;
    assign issue_opa_o   = r_data_a;
    assign issue_opb_o   = r_data_b;

    // FSM and RF in-flight tracking.
    // NOTE: non-blocking assignments make every register here sample the
    // pre-edge values, so the order of statements cannot create a hidden chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_outstanding <= 1'b0;
            r_out_is_b    <= 1'b0;
            r_out_stale   <= 1'b0;
        end else begin
            if (w_resp) begin
                r_outstanding <= 1'b0;
                r_out_stale   <= 1'b0;
            end else if (w_req_hs) begin
                r_outstanding <= 1'b1;
                r_out_is_b    <= w_req_is_b;
            end

            // A read still in flight when a new instruction arrives belongs
            // to the previous one.
            if (w_accept && r_outstanding && !w_resp) begin
                r_out_stale <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state <= w_acc_both ? S_ISSUE : S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (w_have_a_nxt && w_have_b_nxt) begin
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (w_issue_hs) begin
                        if (w_accept) begin
                            r_state <= w_acc_both ? S_ISSUE : S_COLLECT;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Instruction latch and operand capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instr  <= '0;
            r_tag_a  <= '0;
            r_tag_b  <= '0;
            r_need_a <= 1'b0;
            r_need_b <= 1'b0;
            r_have_a <= 1'b0;
            r_have_b <= 1'b0;
            r_data_a <= '0;
            r_data_b <= '0;
        end else if (w_accept) begin
            r_instr  <= instr_i;
            r_tag_a  <= instr_opa_tag_i;
            r_tag_b  <= instr_opb_tag_i;
            r_need_a <= instr_opa_needed_i;
            r_need_b <= instr_opb_needed_i;
            r_have_a <= w_acc_have_a;
            r_have_b <= w_acc_have_b;
            r_data_a <= w_acc_data_a;
            r_data_b <= w_acc_data_b;
        end else if (w_in_collect) begin
            if (w_byp_col_a) begin
                r_have_a <= 1'b1;
                r_data_a <= w_byp_data;
            end else if (w_wr_a) begin
                r_have_a <= 1'b1;
                r_data_a <= rf_resp_data_i;
            end

            if (w_byp_col_b) begin
                r_have_b <= 1'b1;
                r_data_b <= w_byp_data;
            end else if (w_wr_b) begin
                r_have_b <= 1'b1;
                r_data_b <= rf_resp_data_i;
            end
        end
    end

endmodule
